// File: rtl/qed_pkg.sv
// Shared constants for the SQED duplicate-fetch stage: supported opcodes,
// the canonical NOP, cache depth and the duplicate register offset.
package qed_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [31:0] QED_NOP     = 32'h00000013;
  localparam int          QED_DEPTH   = 16;
  localparam int          QED_DUP_OFS = 16;

  function automatic logic qed_supported(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_LUI);
  endfunction

endpackage

// File: rtl/qed_reg_remap.sv
// Combinational remap of an instruction's register fields into the upper
// half of the register file; which fields move depends on the opcode.
module qed_reg_remap
  import qed_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_instr
);

  logic [6:0] w_opc;
  logic       w_rd_en;
  logic       w_rs1_en;
  logic       w_rs2_en;

  // x0 stays x0 so hard-wired zero semantics are identical in both copies
  function automatic logic [4:0] dup_idx(input logic [4:0] idx);
    return (idx == 5'd0) ? idx : (idx | 5'(QED_DUP_OFS));
  endfunction

  always_comb begin
    w_opc    = i_instr[6:0];
    w_rd_en  = (w_opc == OPC_OP) || (w_opc == OPC_OP_IMM) ||
               (w_opc == OPC_LOAD) || (w_opc == OPC_LUI);
    w_rs1_en = (w_opc == OPC_OP) || (w_opc == OPC_OP_IMM) ||
               (w_opc == OPC_LOAD) || (w_opc == OPC_STORE);
    w_rs2_en = (w_opc == OPC_OP) || (w_opc == OPC_STORE);
    o_instr  = i_instr;
    if (w_rd_en)  o_instr[11:7]  = dup_idx(i_instr[11:7]);
    if (w_rs1_en) o_instr[19:15] = dup_idx(i_instr[19:15]);
    if (w_rs2_en) o_instr[24:20] = dup_idx(i_instr[24:20]);
  end

endmodule

// File: rtl/qed_dup_fetch.sv
// SQED fetch stage: records original instructions into a small cache and
// replays them register-remapped in duplicate mode for consistency checking.
module qed_dup_fetch
  import qed_pkg::*;
#(
  parameter int DEPTH  = QED_DEPTH,
  parameter int ADDR_W = 4,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec_dup,
  input  logic              seq_clear,
  input  logic [XLEN-1:0]   ifu_instr,
  input  logic              ifu_valid,
  input  logic              stall,
  output logic [XLEN-1:0]   qed_instr,
  output logic              qed_vld_out,
  output logic              qed_is_dup,
  output logic [ADDR_W:0]   qed_num_orig,
  output logic [ADDR_W:0]   qed_num_dup,
  output logic              qed_check_valid
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  logic [XLEN-1:0]   r_cache [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_num_orig;
  logic [ADDR_W:0]   r_num_dup;
  logic [XLEN-1:0]   r_instr;
  logic              r_vld;
  logic              r_is_dup;
  logic              r_check;

  logic [XLEN-1:0]   w_dup_instr;
  logic              w_go;
  logic              w_record;
  logic              w_issue;
  logic [ADDR_W:0]   w_orig_nxt;
  logic [ADDR_W:0]   w_dup_nxt;

  qed_reg_remap #(.XLEN(XLEN)) u_remap (
    .i_instr (r_cache[r_head]),
    .o_instr (w_dup_instr)
  );

  // seq_clear wins over any record or issue in the same accepted cycle
  always_comb begin
    w_go       = !stall && !seq_clear;
    w_record   = w_go && !exec_dup && ifu_valid &&
                 qed_supported(ifu_instr[6:0]) && (r_num_orig != FULL);
    w_issue    = w_go && exec_dup && (r_num_dup != r_num_orig);
    w_orig_nxt = r_num_orig + {{ADDR_W{1'b0}}, w_record};
    w_dup_nxt  = r_num_dup + {{ADDR_W{1'b0}}, w_issue};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_cache[i] <= '0;
    end else if (w_record) begin
      r_cache[r_tail] <= ifu_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_num_orig <= '0;
      r_num_dup  <= '0;
      r_instr    <= '0;
      r_vld      <= 1'b0;
      r_is_dup   <= 1'b0;
      r_check    <= 1'b0;
    end else if (!stall) begin
      if (seq_clear) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_num_orig <= '0;
        r_num_dup  <= '0;
        r_vld      <= 1'b0;
        r_is_dup   <= 1'b0;
        r_check    <= 1'b0;
      end else begin
        if (w_record) r_tail <= r_tail + 1'b1;
        if (w_issue)  r_head <= r_head + 1'b1;
        r_num_orig <= w_orig_nxt;
        r_num_dup  <= w_dup_nxt;
        r_check    <= r_check || ((w_orig_nxt == w_dup_nxt) && (w_orig_nxt != '0));
        if (exec_dup) begin
          r_vld    <= 1'b1;
          r_is_dup <= w_issue;
          r_instr  <= w_issue ? w_dup_instr : XLEN'(QED_NOP);
        end else if (ifu_valid) begin
          r_vld    <= 1'b1;
          r_is_dup <= 1'b0;
          r_instr  <= w_record ? ifu_instr : XLEN'(QED_NOP);
        end else begin
          r_vld    <= 1'b0;
          r_is_dup <= 1'b0;
        end
      end
    end
  end

  assign qed_instr       = r_instr;
  assign qed_vld_out     = r_vld;
  assign qed_is_dup      = r_is_dup;
  assign qed_num_orig    = r_num_orig;
  assign qed_num_dup     = r_num_dup;
  assign qed_check_valid = r_check;

endmodule

// File: tb/tb_qed_dup_fetch.sv
// Scoreboard bench for qed_dup_fetch: a reference model predicts each output
// instruction and the counters; predictions are queued and popped per output.
module tb_qed_dup_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec_dup;
  logic        seq_clear;
  logic [31:0] ifu_instr;
  logic        ifu_valid;
  logic        stall;
  logic [31:0] qed_instr;
  logic        qed_vld_out;
  logic        qed_is_dup;
  logic [4:0]  qed_num_orig;
  logic [4:0]  qed_num_dup;
  logic        qed_check_valid;

  always #5 clk = ~clk;

  qed_dup_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .exec_dup        (exec_dup),
    .seq_clear       (seq_clear),
    .ifu_instr       (ifu_instr),
    .ifu_valid       (ifu_valid),
    .stall           (stall),
    .qed_instr       (qed_instr),
    .qed_vld_out     (qed_vld_out),
    .qed_is_dup      (qed_is_dup),
    .qed_num_orig    (qed_num_orig),
    .qed_num_dup     (qed_num_dup),
    .qed_check_valid (qed_check_valid)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        dup;
  } exp_t;

  localparam logic [31:0] NOP = 32'h00000013;

  exp_t        sb[$];
  logic [31:0] m_cache [16];
  int          m_head, m_tail, m_norig, m_ndup;
  logic        m_chk;
  logic        last_vld, last_dup;
  logic [31:0] last_instr;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic m_supported(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h37};
  endfunction

  function automatic logic [4:0] m_up(input logic [4:0] idx);
    if (idx == 5'd0 || idx >= 5'd16) return idx;
    return idx + 5'd16;
  endfunction

  function automatic logic [31:0] m_remap(input logic [31:0] i);
    logic [31:0] o;
    o = i;
    if (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h37}) o[11:7]  = m_up(i[11:7]);
    if (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23}) o[19:15] = m_up(i[19:15]);
    if (i[6:0] inside {7'h33, 7'h23})               o[24:20] = m_up(i[24:20]);
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cache[i] = '0;
    m_head = 0; m_tail = 0; m_norig = 0; m_ndup = 0; m_chk = 1'b0;
    sb.delete();
    last_vld = 1'b0; last_dup = 1'b0; last_instr = '0;
  endtask

  task automatic step(input logic dup, input logic v, input logic [31:0] ins,
                      input logic st, input logic clr);
    logic new_out;
    exp_t e;
    @(negedge clk);
    exec_dup = dup; ifu_valid = v; ifu_instr = ins; stall = st; seq_clear = clr;
    new_out = 1'b0;
    if (!st) begin
      if (clr) begin
        m_head = 0; m_tail = 0; m_norig = 0; m_ndup = 0; m_chk = 1'b0;
      end else if (dup) begin
        new_out = 1'b1;
        if (m_ndup < m_norig) begin
          e.instr = m_remap(m_cache[m_head]); e.dup = 1'b1;
          m_head++; m_ndup++;
        end else begin
          e.instr = NOP; e.dup = 1'b0;
        end
        sb.push_back(e);
      end else if (v) begin
        new_out = 1'b1; e.dup = 1'b0;
        if (m_supported(ins) && m_norig < 16) begin
          m_cache[m_tail] = ins; m_tail++; m_norig++; e.instr = ins;
        end else begin
          e.instr = NOP;
        end
        sb.push_back(e);
      end
      if (!clr && m_norig == m_ndup && m_norig != 0) m_chk = 1'b1;
    end
    @(posedge clk);
    #1;
    if (st) begin
      chk("hold_vld", 32'(qed_vld_out), 32'(last_vld));
      chk("hold_instr", qed_instr, last_instr);
      chk("hold_is_dup", 32'(qed_is_dup), 32'(last_dup));
    end else begin
      chk("vld", 32'(qed_vld_out), 32'(new_out));
      last_vld = new_out;
      last_dup = 1'b0;
      if (qed_vld_out) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: got output %h with no expected entry", qed_instr);
        end else begin
          e = sb.pop_front();
          chk("instr", qed_instr, e.instr);
          chk("is_dup", 32'(qed_is_dup), 32'(e.dup));
          last_instr = e.instr;
          last_dup = e.dup;
        end
      end else begin
        chk("is_dup_idle", 32'(qed_is_dup), 32'd0);
      end
    end
    chk("num_orig", 32'(qed_num_orig), 32'(m_norig));
    chk("num_dup", 32'(qed_num_dup), 32'(m_ndup));
    chk("check_valid", 32'(qed_check_valid), 32'(m_chk));
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_instr"}, qed_instr, 32'd0);
    chk({pfx, "_vld"}, 32'(qed_vld_out), 32'd0);
    chk({pfx, "_is_dup"}, 32'(qed_is_dup), 32'd0);
    chk({pfx, "_norig"}, 32'(qed_num_orig), 32'd0);
    chk({pfx, "_ndup"}, 32'(qed_num_dup), 32'd0);
    chk({pfx, "_chkv"}, 32'(qed_check_valid), 32'd0);
  endtask

  logic [6:0]  ops [5];
  logic [31:0] tv [4];
  logic [31:0] r;

  initial begin
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h37;
    rst = 1'b1; exec_dup = 1'b0; seq_clear = 1'b0; ifu_instr = '0;
    ifu_valid = 1'b0; stall = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic record and replay
    step(1'b0, 1'b1, 32'h002081B3, 1'b0, 1'b0);
    chk("add_orig", qed_instr, 32'h002081B3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("add_dup", qed_instr, 32'h012889B3);
    chk("add_chkv", 32'(qed_check_valid), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr_chkv", 32'(qed_check_valid), 32'd0);

    // x0 preservation
    step(1'b0, 1'b1, 32'h00700293, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("x0_dup", qed_instr, 32'h00700A93);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // unsupported opcode
    step(1'b0, 1'b1, 32'h0000006F, 1'b0, 1'b0);
    chk("jal_nop", qed_instr, NOP);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // cache full
    for (int k = 0; k < 17; k++) begin
      r = $urandom();
      step(1'b0, 1'b1, {r[31:7], ops[k % 5]}, 1'b0, 1'b0);
    end
    chk("full_nop", qed_instr, NOP);
    chk("full_norig", 32'(qed_num_orig), 32'd16);
    for (int k = 0; k < 18; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("full_ndup", 32'(qed_num_dup), 32'd16);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // stall and mode toggle
    for (int k = 0; k < 4; k++) begin
      r = $urandom();
      tv[k] = {r[31:7], ops[k]};
      step(1'b0, 1'b1, tv[k], 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("head_two", 32'(dut.r_head), 32'd2);
    step(1'b1, 1'b1, 32'h002081B3, 1'b1, 1'b1);
    chk("stall_head", 32'(dut.r_head), 32'd2);
    chk("stall_tail", 32'(dut.r_tail), 32'd4);
    step(1'b0, 1'b1, 32'h00A30233, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h00C12023, 1'b0, 1'b0);
    chk("tail_six", 32'(dut.r_tail), 32'd6);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("resume_head", qed_instr, m_remap(tv[2]));
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // async reset mid-replay
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h002081B3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h00700293, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    chk("rst_cache0", dut.r_cache[0], 32'd0);
    chk("rst_cache1", dut.r_cache[1], 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; exec_dup = 1'b0; ifu_valid = 1'b0; seq_clear = 1'b0; stall = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_nop", qed_instr, NOP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qed_dup_fetch.md
Name: qed_dup_fetch

Overview:
- SQED instruction-stream stage between the instruction input and the core decode stage.
- In original mode it passes instructions through to the core and records each one in a small cache.
- In duplicate mode it replays the recorded instructions with register indices remapped to the upper half of the register file (x1–x15 → x17–x31).
- It produces the orig/dup counters and qed_check_valid that the SQED consistency checker consumes.

Parameters:
- DEPTH, 16, cache entries; maximum originals per sequence.
- ADDR_W, 4, log2(DEPTH); width of head/tail pointers.
- XLEN, 32, instruction width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- exec_dup  in  1  0 = original mode, 1 = duplicate mode; sampled every accepted cycle
- seq_clear  in  1  synchronous clear of pointers and counters (cache contents kept)
- ifu_instr  in  XLEN  incoming instruction
- ifu_valid  in  1  ifu_instr valid
- stall  in  1  core not accepting; hold all state and outputs
- qed_instr  out  XLEN  instruction to core (registered)
- qed_vld_out  out  1  qed_instr valid
- qed_is_dup  out  1  qed_instr is a replayed duplicate
- qed_num_orig  out  ADDR_W+1  originals recorded
- qed_num_dup  out  ADDR_W+1  duplicates issued
- qed_check_valid  out  1  orig/dup sequences complete and equal

Behaviour:
- Reset (async, rst=1) drives the following to 0:
  - all cache entries
  - address_head and address_tail
  - both counters
  - qed_instr, qed_vld_out, qed_is_dup, qed_check_valid
- Accept condition: ifu_valid && !stall. When stall=1, every register holds.
- Latency: one cycle from an accepted input (or dup issue) to qed_instr/qed_vld_out.
- Supported opcodes:
  - OP (0110011)
  - OP-IMM (0010011)
  - LOAD (0000011)
  - STORE (0100011)
  - LUI (0110111)
- Original mode (exec_dup=0), on accept:
  - Supported opcode and num_orig<DEPTH: write cache[tail], tail++, num_orig++, pass the instruction unchanged, qed_is_dup=0, qed_vld_out=1.
  - Unsupported opcode, or cache full (num_orig==DEPTH): emit NOP 0x00000013, qed_vld_out=1, nothing recorded.
- Duplicate mode (exec_dup=1):
  - ifu_instr is ignored; issue is gated only by !stall.
  - num_dup<num_orig: emit remap(cache[head]), head++, num_dup++, qed_is_dup=1, qed_vld_out=1.
  - num_dup==num_orig: emit NOP, qed_is_dup=0.
- Remap rules:
  - Adding 16 to an index means setting bit 4, and applies only to nonzero indices; x0 is never remapped.
  - rd[11:7] is remapped for OP, OP-IMM, LOAD, LUI.
  - rs1[19:15] is remapped for OP, OP-IMM, LOAD, STORE.
  - rs2[24:20] is remapped for OP, STORE.
  - All immediate, funct3 and funct7 bits pass through untouched.
- qed_check_valid:
  - Registered; equals (num_orig==num_dup) && (num_orig!=0) after each update.
  - Stays 1 until seq_clear or rst.
- Mode switch mid-stream:
  - exec_dup 1→0 before num_dup==num_orig: recording resumes at tail, and pending duplicates stay pending.
  - exec_dup 0→1: takes effect on the next accepted cycle, with no bubble.
- seq_clear:
  - Zeroes head, tail, both counters and qed_check_valid next cycle.
  - Overrides any simultaneous record or issue.
  - Ignored when stall=1 (held until accepted).
- Pointer wrap: head and tail never exceed DEPTH per sequence, so they never wrap; tail saturates at num_orig==DEPTH.

Decomposition:
- Shared package qed_pkg holds:
  - opcode localparams
  - QED_NOP = 32'h00000013
  - QED_DEPTH default
  - a register-offset constant QED_DUP_OFS = 16
- Combinational sub-module qed_reg_remap (instr in → remapped instr out), opcode-driven per the rules above.

Test Plan:
- Basic record and replay:
  - exec_dup=0, send add x3,x1,x2 0x002081B3 → qed_instr=0x002081B3, num_orig=1.
  - Then exec_dup=1 → qed_instr=0x012889B3 (rd=19, rs1=17, rs2=18), qed_is_dup=1, num_dup=1, qed_check_valid=1 one cycle later.
- x0 preservation: orig addi x5,x0,7 0x00700293 → dup output 0x00700A93 (rs1 stays x0).
- Cache full:
  - Send 17 supported instructions in orig mode → the 17th outputs 0x00000013.
  - num_orig saturates at 16; dup then issues exactly 16 before NOPs.
- Stall and mode toggle:
  - Assert stall during dup issue → qed_instr, head and num_dup held.
  - Toggle exec_dup 1→0→1 after 2 of 4 dups → new originals are appended at tail=4, and replay continues from head=2.
- Unsupported opcode: JAL (1101111) in orig mode → NOP output, num_orig unchanged.
- Reset and seq_clear:
  - Assert rst mid-replay → all outputs and counters 0 asynchronously, and cache reads 0.
  - seq_clear with qed_check_valid=1 → counters and qed_check_valid = 0 next cycle.
